// File: rtl/sr_bank_pkg.sv
// Shared encodings for the SR storage bank: conflict policies and per-channel commands.
package sr_bank_pkg;

  localparam logic [1:0] MODE_HOLD    = 2'd0;
  localparam logic [1:0] MODE_SET_DOM = 2'd1;
  localparam logic [1:0] MODE_RST_DOM = 2'd2;
  localparam logic [1:0] MODE_TOGGLE  = 2'd3;

  // Command is {s, r}
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

endpackage

// File: rtl/sr_chan.sv
// One filtered set/reset storage channel with a policy-resolved S=R=1 case
// and a sticky conflict flag.
module sr_chan
  import sr_bank_pkg::*;
#(
  parameter int FILTER = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s,
  input  logic       r,
  input  logic [1:0] mode,
  input  logic       err_clr,
  output logic       q,
  output logic       err_flag,
  output logic       fire_conflict
);

  localparam int FW = $clog2(FILTER + 1);
  localparam logic [FW-1:0] FILT = FW'(FILTER);

  logic [FW-1:0] cnt_p0, cnt_nxt;
  logic [1:0]    prev_cmd_p0;
  logic [1:0]    cmd;
  logic          armed_p0, armed_nxt, arm_eff;
  logic          q_p0, q_nxt;
  logic          err_flag_p0;
  logic          fire;

  function automatic logic resolve_conflict(input logic q_cur, input logic [1:0] pol);
    case (pol)
      MODE_SET_DOM: resolve_conflict = 1'b1;
      MODE_RST_DOM: resolve_conflict = 1'b0;
      MODE_TOGGLE:  resolve_conflict = ~q_cur;
      default:      resolve_conflict = q_cur;
    endcase
  endfunction

  always_comb begin
    cmd     = {s, r};
    cnt_nxt = cnt_p0;
    arm_eff = armed_p0;
    // A new or idle command re-arms; a held one only advances toward FILTER.
    if (cmd == CMD_IDLE) begin
      cnt_nxt = '0;
      arm_eff = 1'b1;
    end else if (cmd != prev_cmd_p0) begin
      cnt_nxt = FW'(1);
      arm_eff = 1'b1;
    end else if (cnt_p0 != FILT) begin
      cnt_nxt = cnt_p0 + FW'(1);
    end
    fire          = (cmd != CMD_IDLE) && arm_eff && (cnt_nxt == FILT);
    armed_nxt     = arm_eff && !fire;
    fire_conflict = fire && (cmd == CMD_BOTH);
    q_nxt         = q_p0;
    if (fire) begin
      case (cmd)
        CMD_SET: q_nxt = 1'b1;
        CMD_RST: q_nxt = 1'b0;
        default: q_nxt = resolve_conflict(q_p0, mode);
      endcase
    end
  end

  // ---- stage p0: channel state registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0      <= '0;
      prev_cmd_p0 <= CMD_IDLE;
      armed_p0    <= 1'b1;
      q_p0        <= 1'b0;
      err_flag_p0 <= 1'b0;
    end else begin
      cnt_p0      <= cnt_nxt;
      prev_cmd_p0 <= cmd;
      armed_p0    <= armed_nxt;
      q_p0        <= q_nxt;
      if (fire_conflict)
        err_flag_p0 <= 1'b1;
      else if (err_clr)
        err_flag_p0 <= 1'b0;
    end
  end

  assign q        = q_p0;
  assign err_flag = err_flag_p0;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N filtered SR storage channels with a bank-wide saturating count
// of qualified S=R=1 conflict events.
module sr_latch_bank
  import sr_bank_pkg::*;
#(
  parameter int N      = 4,
  parameter int FILTER = 2,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  s,
  input  logic [N-1:0]  r,
  input  logic [1:0]    mode,
  input  logic          err_clr,
  output logic [N-1:0]  q,
  output logic [N-1:0]  q_n,
  output logic [N-1:0]  err_flag,
  output logic [CW-1:0] err_count
);

  localparam int CNT_MAX = (1 << CW) - 1;

  logic [N-1:0]  fire_conflict;
  logic [CW-1:0] err_count_p1;
  logic [3:0]    conf_k;

  function automatic logic [3:0] popcount(input logic [N-1:0] bits);
    popcount = '0;
    for (int i = 0; i < N; i++)
      popcount = popcount + {3'b000, bits[i]};
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] base, input logic [3:0] k);
    int sum;
    sum = int'(base) + int'(k);
    sat_add = (sum > CNT_MAX) ? CW'(CNT_MAX) : CW'(sum);
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_chan
    sr_chan #(.FILTER(FILTER)) u_chan (
      .clk           (clk),
      .rst           (rst),
      .s             (s[i]),
      .r             (r[i]),
      .mode          (mode),
      .err_clr       (err_clr),
      .q             (q[i]),
      .err_flag      (err_flag[i]),
      .fire_conflict (fire_conflict[i])
    );
  end

  assign conf_k = popcount(fire_conflict);

  // ---- stage p1: bank conflict counter; same-edge events survive a clear ----
  always_ff @(posedge clk) begin
    if (rst)
      err_count_p1 <= '0;
    else
      err_count_p1 <= sat_add(err_clr ? '0 : err_count_p1, conf_k);
  end

  assign err_count = err_count_p1;
  assign q_n       = ~q;

endmodule
